button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 139 +++++++++++++
 tb/tb_button_debounce.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Multi-channel button debouncer with 2-flop synchronizers, per-channel
// STABLE/CHECKING FSMs and an Avalon-MM register block (period, status, glitch count).
module button_debounce #(
  parameter int unsigned     WIDTH          = 4,
  parameter int unsigned     CNT_WIDTH      = 20,
  parameter int unsigned     DEFAULT_PERIOD = 500000,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] db_out,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata
);

  localparam int unsigned NUM_W   = $clog2(WIDTH + 1);
  localparam int unsigned GLT_W   = 16;
  localparam int unsigned GSUM_W  = GLT_W + 1;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHECKING = 1'b1
  } state_e;

  logic [WIDTH-1:0]     sync1_q, sync2_q;
  logic [WIDTH-1:0]     db_q, db_d;
  state_e               state_q [WIDTH];
  state_e               state_d [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d   [WIDTH];
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [GLT_W-1:0]     glitch_q, glitch_d;
  logic [31:0]          readdata_q, readdata_d;

  logic [WIDTH-1:0]     glitch_hit;
  logic [NUM_W-1:0]     glitch_num;
  logic [GSUM_W-1:0]    glitch_sum;
  logic [CNT_WIDTH-1:0] period_last;
  logic                 wr_en;
  logic                 unused_wdata;

  assign unused_wdata = ^writedata[31:CNT_WIDTH];
  assign wr_en        = chipselect & ~write_n;
  // A zero period behaves as a period of one.
  assign period_last  = (period_q == '0) ? '0 : period_q - CNT_WIDTH'(1);

  assign db_out   = db_q;
  assign readdata = readdata_q;

  // Per-channel debounce FSMs
  always_comb begin
    db_d       = db_q;
    glitch_hit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != db_q[i]) begin
            state_d[i] = ST_CHECKING;
            cnt_d[i]   = '0;
          end
        end
        ST_CHECKING: begin
          if (sync2_q[i] == db_q[i]) begin
            state_d[i]    = ST_STABLE;
            glitch_hit[i] = 1'b1;
          end else if (cnt_q[i] >= period_last) begin
            db_d[i]    = sync2_q[i];
            state_d[i] = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        default: state_d[i] = ST_STABLE;
      endcase
    end
  end

  // Register block: period write, saturating glitch counter, read mux
  always_comb begin
    period_d   = period_q;
    glitch_num = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      glitch_num = glitch_num + NUM_W'(glitch_hit[i]);
    end
    glitch_sum = GSUM_W'(glitch_q) + GSUM_W'(glitch_num);

    if (wr_en && address == 2'd2) begin
      glitch_d = '0;
    end else if (glitch_sum[GLT_W]) begin
      glitch_d = '1;
    end else begin
      glitch_d = glitch_sum[GLT_W-1:0];
    end

    if (wr_en && address == 2'd0) begin
      period_d = writedata[CNT_WIDTH-1:0];
    end

    case (address)
      2'd0:    readdata_d = 32'(period_q);
      2'd1:    readdata_d = 32'({sync2_q, db_q});
      2'd2:    readdata_d = 32'(glitch_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= RESET_LEVEL;
      sync2_q    <= RESET_LEVEL;
      db_q       <= RESET_LEVEL;
      period_q   <= CNT_WIDTH'(DEFAULT_PERIOD);
      glitch_q   <= '0;
      readdata_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      period_q   <= period_d;
      glitch_q   <= glitch_d;
      readdata_q <= readdata_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random traffic checked
// against a run-length reference model of the debounce rules.
module tb_button_debounce;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  btn_in;
  logic [3:0]  db_out;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0]  m_s1, m_s2, m_db;
  int          m_run [4];
  int          m_period;
  int          m_glitch;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  button_debounce dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .db_out     (db_out),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  task automatic model_reset();
    m_s1     = 4'hF;
    m_s2     = 4'hF;
    m_db     = 4'hF;
    m_period = 500000;
    m_glitch = 0;
    m_rd     = 32'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  // A level flips once it has differed from the output for period+1 consecutive
  // synchronized samples; a run ending early counts as one glitch.
  task automatic tick();
    int          g;
    int          eff;
    logic [31:0] rd_n;
    logic [3:0]  db_n;
    if (reset_n) begin
      case (address)
        2'd0:    rd_n = 32'(m_period);
        2'd1:    rd_n = {24'h0, m_s2, m_db};
        2'd2:    rd_n = 32'(m_glitch);
        default: rd_n = 32'h0;
      endcase
      eff  = (m_period == 0) ? 1 : m_period;
      g    = 0;
      db_n = m_db;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= eff + 1) begin
            db_n[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0) g = g + 1;
          m_run[i] = 0;
        end
      end
      m_db = db_n;
      if (chipselect && !write_n && address == 2'd2) m_glitch = 0;
      else m_glitch = (m_glitch + g > 65535) ? 65535 : m_glitch + g;
      if (chipselect && !write_n && address == 2'd0) m_period = int'(writedata & 32'h000F_FFFF);
      m_s2 = m_s1;
      m_s1 = btn_in;
      m_rd = rd_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL reset_db: got %h expected %h", db_out, 4'hF); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'h0); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(2'd0);
    n_checks++;
    if (readdata !== 32'd500000) begin n_fail++; $display("FAIL reset_period: got %0d expected %0d", readdata, 500000); end
    bus_read(2'd2);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_glitch: got %h expected %h", readdata, 32'h0); end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    bus_write(2'd0, 32'd4);
    btn_in = 4'hE;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k < 6) ? 4'hF : 4'hE;
      n_checks++;
      if (db_out !== exp) begin n_fail++; $display("FAIL press_edge%0d: got %h expected %h", k, db_out, exp); end
    end
    bus_read(2'd1);
    n_checks++;
    if (readdata !== 32'h0000_00EE) begin n_fail++; $display("FAIL press_status: got %h expected %h", readdata, 32'hEE); end
    btn_in = 4'hF;
    repeat (10) tick();
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL press_release: got %h expected %h", db_out, 4'hF); end
  endtask

  task automatic test_bounce();
    bus_write(2'd2, 32'h0);
    btn_in = 4'hD;
    repeat (3) tick();
    btn_in = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (db_out !== 4'hF) begin n_fail++; $display("FAIL bounce_db%0d: got %h expected %h", k, db_out, 4'hF); end
    end
    bus_read(2'd2);
    n_checks++;
    if (readdata !== 32'd1) begin n_fail++; $display("FAIL bounce_glitch: got %0d expected %0d", readdata, 1); end
  endtask

  task automatic test_simul_glitch();
    bus_write(2'd2, 32'h0);
    btn_in = 4'h3;
    repeat (2) tick();
    btn_in = 4'hF;
    repeat (6) tick();
    bus_read(2'd2);
    n_checks++;
    if (readdata !== 32'd2) begin n_fail++; $display("FAIL dual_glitch: got %0d expected %0d", readdata, 2); end
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL dual_db: got %h expected %h", db_out, 4'hF); end
    // Second glitch lands on the same edge as the clear write.
    btn_in = 4'hB;
    repeat (2) tick();
    btn_in = 4'hF;
    repeat (2) tick();
    bus_write(2'd2, 32'h0);
    bus_read(2'd2);
    n_checks++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL clear_wins: got %0d expected %0d", readdata, 0); end
    repeat (4) tick();
    bus_read(2'd2);
    n_checks++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL clear_stays: got %0d expected %0d", readdata, 0); end
  endtask

  task automatic test_period_shrink();
    bus_write(2'd0, 32'd100);
    btn_in = 4'hE;
    repeat (13) tick();
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL shrink_before: got %h expected %h", db_out, 4'hF); end
    bus_write(2'd0, 32'd5);
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL shrink_write: got %h expected %h", db_out, 4'hF); end
    tick();
    n_checks++;
    if (db_out !== 4'hE) begin n_fail++; $display("FAIL shrink_commit: got %h expected %h", db_out, 4'hE); end
    btn_in = 4'hF;
    repeat (12) tick();
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL shrink_release: got %h expected %h", db_out, 4'hF); end
  endtask

  task automatic test_reset_mid_check();
    bus_write(2'd0, 32'd100);
    btn_in = 4'hE;
    repeat (20) tick();
    bus_read(2'd0);
    n_checks++;
    if (readdata !== 32'd100) begin n_fail++; $display("FAIL midrst_pre: got %0d expected %0d", readdata, 100); end
    #2 reset_n = 1'b0;
    model_reset();
    btn_in = 4'hF;
    #1;
    n_checks++;
    if (db_out !== 4'hF) begin n_fail++; $display("FAIL midrst_db: got %h expected %h", db_out, 4'hF); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rd: got %h expected %h", readdata, 32'h0); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 120; k++) begin
      tick();
      n_checks++;
      if (db_out !== 4'hF) begin n_fail++; $display("FAIL midrst_hold%0d: got %h expected %h", k, db_out, 4'hF); end
    end
    bus_read(2'd0);
    n_checks++;
    if (readdata !== 32'd500000) begin n_fail++; $display("FAIL midrst_period: got %0d expected %0d", readdata, 500000); end
  endtask

  task automatic test_random();
    int hold;
    bus_write(2'd0, 32'(($urandom & 32'hFFF0_0000) | $urandom_range(0, 6)));
    for (int s = 0; s < 400; s++) begin
      btn_in = 4'($urandom);
      hold   = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        address    = 2'($urandom);
        chipselect = 1'($urandom);
        write_n    = ($urandom_range(0, 7) != 0);
        writedata  = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 6));
        tick();
        n_checks++;
        if (db_out !== m_db) begin n_fail++; $display("FAIL rand_db s%0d: got %h expected %h", s, db_out, m_db); end
        n_checks++;
        if (readdata !== m_rd) begin n_fail++; $display("FAIL rand_rd s%0d: got %h expected %h", s, readdata, m_rd); end
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b1;
    btn_in     = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simul_glitch();
    test_period_shrink();
    test_reset_mid_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
